// File: rtl/pg_multi_if.sv
// Configuration and pulse-output bundle for pg_multi.
// Host-side master drives settings/triggers; the generator is the slave.
interface pg_multi_if #(
  parameter int CNT_W = 24,
  parameter int N_CH  = 4
);
  logic                   i_en;
  logic [CNT_W-1:0]       i_period;
  logic [N_CH*CNT_W-1:0]  i_st;
  logic [N_CH*CNT_W-1:0]  i_end;
  logic [N_CH-1:0]        i_mode;
  logic [N_CH-1:0]        i_pol;
  logic [N_CH-1:0]        i_trig;
  logic [N_CH-1:0]        o_pulse;
  logic [CNT_W-1:0]       o_cnt;
  logic                   o_wrap;
  logic [N_CH-1:0]        o_armed;

  modport master (
    output i_en, i_period, i_st, i_end,
    output i_mode, i_pol, i_trig,
    input  o_pulse, o_cnt, o_wrap, o_armed
  );

  modport slave (
    input  i_en, i_period, i_st, i_end,
    input  i_mode, i_pol, i_trig,
    output o_pulse, o_cnt, o_wrap, o_armed
  );
endinterface

// File: rtl/pg_multi.sv
// Multi-channel pulse generator on one shared period counter.
// Settings are shadowed and take effect only at period boundaries.
module pg_multi #(
  parameter int CNT_W = 24,
  parameter int N_CH  = 4
) (
  input  logic        i_clk,
  input  logic        i_res,
  pg_multi_if.slave   bus
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        wrap_q, wrap_d;
  logic [CNT_W-1:0]            per_q;
  logic [N_CH-1:0][CNT_W-1:0]  st_q, end_q;
  logic [N_CH-1:0]             mode_q, pol_q;
  logic [N_CH-1:0]             armed_q, armed_d;
  logic [N_CH-1:0]             fire_q, fire_d;
  logic [N_CH-1:0]             raw_q, raw_d;
  logic [N_CH-1:0]             hit, inw, qual;
  logic                        last, ld;

  always_comb begin
    last   = (cnt_q == per_q - ONE);
    ld     = ~bus.i_en | last;
    cnt_d  = '0;
    wrap_d = 1'b0;
    if (bus.i_en) begin
      cnt_d  = last ? '0 : cnt_q + ONE;
      wrap_d = last;
    end
  end

  // one-shot: fire latch covers the window after the armed hit at st
  always_comb begin
    hit     = '0;
    inw     = '0;
    qual    = '0;
    raw_d   = '0;
    fire_d  = '0;
    armed_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit[k]  = mode_q[k] & armed_q[k]
              & (cnt_q == st_q[k]);
      inw[k]  = (cnt_q >= st_q[k])
              & (cnt_q < end_q[k]);
      qual[k] = ~mode_q[k] | fire_q[k] | hit[k];
      raw_d[k] = bus.i_en & inw[k] & qual[k];
      fire_d[k] = bus.i_en
                & (fire_q[k] | hit[k])
                & ~(cnt_q == end_q[k] - ONE)
                & ~last;
      armed_d[k] = bus.i_en
                 & (bus.i_trig[k]
                    | (armed_q[k] & ~hit[k]));
    end
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      per_q   <= '0;
      st_q    <= '0;
      end_q   <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
      armed_q <= '0;
      fire_q  <= '0;
      raw_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      armed_q <= armed_d;
      fire_q  <= fire_d;
      raw_q   <= raw_d;
      if (ld) begin
        per_q  <= bus.i_period;
        st_q   <= bus.i_st;
        end_q  <= bus.i_end;
        mode_q <= bus.i_mode;
        pol_q  <= bus.i_pol;
      end
    end
  end

  assign bus.o_pulse = raw_q ^ pol_q;
  assign bus.o_cnt   = cnt_q;
  assign bus.o_wrap  = wrap_q;
  assign bus.o_armed = armed_q;
endmodule

// File: tb/tb_pg_multi.sv
// Directed + randomized bench for pg_multi against an integer model.
module tb_pg_multi;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  pg_multi_if #(.CNT_W(W), .N_CH(N)) bus();

  pg_multi #(.CNT_W(W), .N_CH(N)) dut (
    .i_clk (clk),
    .i_res (res),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt, m_psh;
  bit m_wrap;
  int m_st[N], m_end[N];
  bit m_mode[N], m_pol[N];
  bit m_arm[N], m_fire[N], m_raw[N];

  function void m_reset();
    m_cnt = 0; m_psh = 0; m_wrap = 0;
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_end[k] = 0;
      m_mode[k] = 0; m_pol[k] = 0;
      m_arm[k] = 0; m_fire[k] = 0; m_raw[k] = 0;
    end
  endfunction

  function void m_load();
    m_psh = int'(bus.i_period);
    for (int k = 0; k < N; k++) begin
      m_st[k]   = int'(bus.i_st[k*W +: W]);
      m_end[k]  = int'(bus.i_end[k*W +: W]);
      m_mode[k] = bus.i_mode[k];
      m_pol[k]  = bus.i_pol[k];
    end
  endfunction

  // one clock of behaviour, using the inputs as sampled at the edge
  function void m_step();
    int  plen;
    bit  last, shot, inw;
    if (res) begin
      m_reset();
      return;
    end
    if (!bus.i_en) begin
      m_cnt = 0; m_wrap = 0;
      for (int k = 0; k < N; k++) begin
        m_raw[k] = 0; m_arm[k] = 0; m_fire[k] = 0;
      end
      m_load();
      return;
    end
    plen = (m_psh == 0) ? (1 << W) : m_psh;
    last = (m_cnt == plen - 1);
    for (int k = 0; k < N; k++) begin
      shot = m_mode[k] && m_arm[k] && (m_cnt == m_st[k]);
      inw  = (m_cnt >= m_st[k]) && (m_cnt < m_end[k]);
      m_raw[k]  = inw && (!m_mode[k] || m_fire[k] || shot);
      m_fire[k] = (m_fire[k] || shot) && !last
                  && (m_cnt != m_end[k] - 1);
      if (bus.i_trig[k]) m_arm[k] = 1;
      else if (shot)     m_arm[k] = 0;
    end
    m_cnt  = last ? 0 : m_cnt + 1;
    m_wrap = last;
    if (last) m_load();
  endfunction

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [N-1:0] ep, ea;
    for (int k = 0; k < N; k++) begin
      ep[k] = m_raw[k] ^ m_pol[k];
      ea[k] = m_arm[k];
    end
    cmp({tag, ".cnt"},   32'(bus.o_cnt),   32'(m_cnt));
    cmp({tag, ".wrap"},  32'(bus.o_wrap),  32'(m_wrap));
    cmp({tag, ".pulse"}, 32'(bus.o_pulse), 32'(ep));
    cmp({tag, ".armed"}, 32'(bus.o_armed), 32'(ea));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(string tag, int n, int tprob);
    for (int i = 0; i < n; i++) begin
      if (tprob > 0)
        for (int k = 0; k < N; k++)
          bus.i_trig[k] = ($urandom_range(99) < tprob);
      tick(tag);
    end
    bus.i_trig = '0;
  endtask

  task automatic wait_cnt(string tag, int c);
    for (int g = 0; g < 300 && m_cnt != c; g++) tick(tag);
  endtask

  task automatic trig1(string tag, int k);
    bus.i_trig[k] = 1'b1;
    tick(tag);
    bus.i_trig[k] = 1'b0;
  endtask

  task automatic set_ch(int k, int s, int e, bit md, bit pl);
    bus.i_st[k*W +: W]  = W'(s);
    bus.i_end[k*W +: W] = W'(e);
    bus.i_mode[k] = md;
    bus.i_pol[k]  = pl;
  endtask

  initial begin
    int p;
    bus.i_en = 0; bus.i_period = '0;
    bus.i_st = '0; bus.i_end = '0;
    bus.i_mode = '0; bus.i_pol = '0; bus.i_trig = '0;
    m_reset();
    #1 check_all("reset");
    @(negedge clk);
    tick("reset_hold");
    res = 1'b0;
    run("idle", 3, 0);

    // continuous + inverted empty window
    bus.i_period = W'(10);
    set_ch(0, 2, 5, 0, 0);
    set_ch(1, 7, 7, 0, 1);
    tick("cfg");
    bus.i_en = 1;
    run("cont", 25, 0);
    wait_cnt("cont", 4);
    set_ch(1, 0, 1, 0, 1);
    run("shadow", 22, 0);

    // one-shot basics
    bus.i_en = 0;
    bus.i_period = W'(8);
    set_ch(2, 3, 6, 1, 0);
    tick("os_cfg");
    bus.i_en = 1;
    wait_cnt("os", 1);
    trig1("os_trig", 2);
    run("os", 24, 0);
    wait_cnt("late", 4);
    trig1("late_trig", 2);
    run("late", 20, 0);
    wait_cnt("dbl", 0);
    trig1("dbl_a", 2);
    tick("dbl_gap");
    trig1("dbl_b", 2);
    run("dbl", 20, 0);
    wait_cnt("rearm", 2);
    trig1("rearm_a", 2);
    trig1("rearm_b", 2);
    run("rearm", 20, 0);

    // edge periods
    bus.i_period = W'(1);
    run("p1", 12, 0);
    bus.i_period = '0;
    run("p0", 270, 0);

    // randomized configurations
    for (int b = 0; b < 24; b++) begin
      p = $urandom_range(24, 1);
      bus.i_period = W'(p);
      for (int k = 0; k < N; k++)
        set_ch(k, $urandom_range(p + 2), $urandom_range(p + 2),
               1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(5) == 0) bus.i_en = ~bus.i_en;
      else bus.i_en = 1;
      run("rand", 25, 8);
    end

    // disable and async reset mid-pulse
    bus.i_en = 1;
    bus.i_period = W'(10);
    set_ch(0, 2, 6, 0, 1);
    set_ch(2, 3, 6, 1, 0);
    wait_cnt("dis_sync", 0);
    run("dis_pre", 12, 0);
    trig1("dis_trig", 2);
    for (int g = 0; g < 40 && !m_raw[0]; g++) tick("dis_wait");
    bus.i_en = 0;
    tick("dis");
    bus.i_en = 1;
    wait_cnt("rst_sync", 0);
    trig1("rst_trig", 2);
    for (int g = 0; g < 40 && !m_raw[0]; g++) tick("rst_wait");
    res = 1'b1;
    #1;
    cmp("async.pulse", 32'(bus.o_pulse), 32'(0));
    cmp("async.cnt",   32'(bus.o_cnt),   32'(0));
    cmp("async.armed", 32'(bus.o_armed), 32'(0));
    cmp("async.wrap",  32'(bus.o_wrap),  32'(0));
    m_reset();
    tick("rst_hold");
    res = 1'b0;
    run("post_rst", 15, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pg_multi.md
Name: pg_multi

Overview:
- Multi-channel, parametrised pulse generator built on one shared period counter.
- Each channel drives one output pulse inside every counter period, defined by a start/end compare window.
- Per channel: continuous or triggered one-shot mode, and selectable output polarity.
- Settings go through shadow registers and apply only at period boundaries, so outputs never glitch during reconfiguration.
- Sits between the host configuration registers and the pulse output pins.

Parameters:
- CNT_W, 24, width of the period counter and of all compare values.
- N_CH, 4, number of pulse channels.

Ports:
- i_clk  in  1  system clock.
- i_res  in  1  asynchronous reset, active-high.
- i_en  in  1  run enable for the counter and all channels.
- i_period  in  CNT_W  period length in clocks; 0 means 2^CNT_W.
- i_st  in  N_CH*CNT_W  per-channel start compare; channel k uses bits [k*CNT_W +: CNT_W].
- i_end  in  N_CH*CNT_W  per-channel end compare; same packing as i_st.
- i_mode  in  N_CH  per channel: 0 = continuous, 1 = one-shot.
- i_pol  in  N_CH  per channel: 1 = inverted output.
- i_trig  in  N_CH  per-channel one-shot arm strobe, level sampled each clock.
- o_pulse  out  N_CH  pulse outputs.
- o_cnt  out  CNT_W  current counter value.
- o_wrap  out  1  one-cycle strobe at each period start.
- o_armed  out  N_CH  one-shot armed flags.

Behaviour:
- Reset (async, i_res=1): counter=0, all shadow registers=0, armed flags=0, o_pulse=0, o_wrap=0, o_armed=0.

Counter:
- i_en=0: counter held at 0 (synchronous clear); o_wrap=0.
- i_en=1: counter increments by 1 per clock.
- When cnt == period_sh-1, the counter wraps to 0 on the next clock, and o_wrap=1 during that first cnt=0 cycle.
- period_sh=0 gives a free-running wrap at 2^CNT_W-1.
- period_sh=1 keeps cnt=0 and holds o_wrap=1 every cycle.
- The first cycle after i_en rises has cnt=0 and o_wrap=0.

Shadowing:
- period_sh, st_sh, end_sh, mode_sh and pol_sh load from the inputs every clock while i_en=0.
- While i_en=1 they load only on the clock where cnt == period_sh-1, so new values take effect from the next period.
- Input changes mid-period have no effect on the current period.

Window qualification, channel k:
- in_win = (st_sh <= cnt < end_sh), unsigned compare.
- st_sh >= end_sh gives an empty window; wrap-around windows are not supported.
- Window bounds at or beyond period_sh are simply never reached.

Pulse output, channel k:
- Output is registered: raw(t+1) = in_win(t) AND qual(t), then o_pulse = raw XOR pol_sh.
- o_pulse therefore lags o_cnt by exactly 1 cycle, and pulse width = end_sh - st_sh clocks.

Continuous mode (mode_sh=0):
- qual=1, so the channel pulses every period.

One-shot mode (mode_sh=1):
- i_trig=1 sets the armed flag, which appears on o_armed the next clock.
- At cnt == st_sh with armed=1, a per-channel fire latch is set; qual = fire latch OR (cnt==st_sh AND armed).
- Armed is cleared on that same clock.
- The fire latch clears when cnt == end_sh-1, or at wrap, whichever comes first.
- A trigger arriving inside the window (cnt > st_sh) never produces a partial pulse; it fires in the next period.
- i_trig asserted on the same clock that armed is consumed re-arms the channel, so one more pulse follows in the next period.
- Multiple triggers while already armed collapse to a single pulse.

Disable and mode change:
- i_en=0 clears armed flags and fire latches; o_pulse goes to its idle level, which is pol_sh.
- A mode change takes effect at the shadow load; a pending armed flag survives the change.

Channels are fully independent and share only the counter.

Test Plan:
- Continuous mode: period=10, ch0 st=2 end=5, pol=0 -> o_pulse[0] high while o_cnt = 3,4,5 in every period; o_wrap high whenever o_cnt=0 after a wrap.
- Polarity and empty window: ch1 pol=1, st=7 end=7 -> o_pulse[1] held at 1 permanently; set st=0 end=1 mid-period -> a single low cycle appears only from the next period (shadow check).
- One-shot basics: period=8, ch2 mode=1 st=3 end=6; pulse i_trig[2] while cnt=1 -> exactly one pulse (3 clocks, o_cnt = 4,5,6) and o_armed[2] drops at cnt=3; no pulse in later periods.
- One-shot late trigger: same setup, trigger at cnt=4 -> no pulse this period, full pulse next period; trigger twice before st -> only one pulse.
- Edge periods: period=1 -> o_wrap constantly 1 and o_cnt=0; period=0 with CNT_W=4 -> counter runs 0..15, then wraps.
- Reset and disable: assert i_res mid-pulse -> o_pulse=0, o_cnt=0 and o_armed=0 immediately (asynchronously); drop i_en mid-pulse -> o_pulse returns to pol_sh the next clock and armed is cleared.
